// File: rtl/paraleloserial_param.sv
// Parallel-to-serial shifter: words are loaded on READY edges and sent back to back, with IDLE_WORD filling empty slots.
// Latency: the first bit of a word is on OS one edge after its load. Backpressure: READY only at the last bit or in OFF.
module paraleloserial_param #(
    parameter int              WIDTH     = 10,
    parameter bit              MSB_FIRST = 1'b0,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(10'b0101111100)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             os_o,
    output logic             word_start_o,
    output logic             underrun_o
);
    localparam int              CW   = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {OFF, RUN} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             word_start_q, word_start_d;
    logic             underrun_q, underrun_d;
    logic             load;

    assign load    = enable_i && (state_q == OFF || count_q == LAST);
    assign ready_o = load && !rst_i;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shreg_d      = shreg_q;
        word_start_d = 1'b0;
        underrun_d   = 1'b0;
        if (!enable_i) begin
            // Abort wins over any pending load: the partial word is discarded.
            state_d = OFF;
            count_d = '0;
            shreg_d = '0;
        end else if (load) begin
            state_d      = RUN;
            count_d      = '0;
            shreg_d      = valid_i ? d_i : IDLE_WORD;
            word_start_d = 1'b1;
            underrun_d   = (state_q == RUN) && !valid_i;
        end else if (state_q == RUN) begin
            count_d = count_q + CW'(1);
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= OFF;
            count_q      <= '0;
            shreg_q      <= '0;
            word_start_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shreg_q      <= shreg_d;
            word_start_q <= word_start_d;
            underrun_q   <= underrun_d;
        end
    end

    assign os_o         = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign word_start_o = word_start_q;
    assign underrun_o   = underrun_q;
endmodule
